// File: rtl/spi_slave_core_if.sv
// SPI slave bus bundle: the four SPI pins plus the word-level tx/rx
// handshake seen by the system-clock side.
interface spi_slave_core_if #(
  parameter int data_width = 16
);
  logic                  sclk;
  logic                  mosi;
  logic                  ss;
  logic                  miso;
  logic                  miso_oe;
  logic [data_width-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [data_width-1:0] rx_data;
  logic                  rx_valid;
  logic                  tx_underrun;
  logic                  busy;

  // The SPI slave core: receives the pins and the word to send.
  modport slave (
    input  sclk, mosi, ss, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  // The surrounding system / SPI master driving the core.
  modport master (
    output sclk, mosi, ss, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
endinterface

// File: rtl/spi_slave_core.sv
// spi_slave_core: oversampled SPI slave. The SPI pins are synchronized into
// the clk domain and sclk edges are detected there, so nothing runs on sclk.
// Full duplex: every received word is paired with one transmitted word taken
// from a single-entry holding register.
// Optional build macro SPI_SLAVE_LSB_FIRST_EN: shift LSB first on both miso
// and mosi (default is MSB first).
module spi_slave_core #(
  parameter bit clk_polarity = 1'b0,
  parameter bit clk_phase    = 1'b0,
  parameter int data_width   = 16
) (
  input logic             clk,
  input logic             rst_n,
  spi_slave_core_if.slave bus
);

  localparam int cnt_w = $clog2(data_width);
  localparam logic [cnt_w-1:0] last_bit = cnt_w'(data_width - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_next;

  logic sclk_meta, sclk_sync, sclk_prev;
  logic mosi_meta, mosi_sync;
  logic ss_meta, ss_sync, ss_prev;
  logic [1:0] settle;
  logic ss_armed;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge;
  logic ss_fall, ss_rise;

  logic busy_int, word_start, active_run, exit_word;

  logic [data_width-1:0] tx_shift, rx_shift, rx_next, hold_data, rx_data_q;
  logic [cnt_w-1:0] bit_cnt;
  logic hold_full, arm_pending, skip_shift;
  logic rx_valid_q, tx_underrun_q;
  logic word_done, load_next, do_load, do_shift, tx_accept;

  // Two-flop synchronizers on the pins plus one more stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_meta <= clk_polarity;
      sclk_sync <= clk_polarity;
      sclk_prev <= clk_polarity;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
      ss_meta   <= 1'b1;
      ss_sync   <= 1'b1;
      ss_prev   <= 1'b1;
    end else begin
      sclk_meta <= bus.sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      mosi_meta <= bus.mosi;
      mosi_sync <= mosi_meta;
      ss_meta   <= bus.ss;
      ss_sync   <= ss_meta;
      ss_prev   <= ss_sync;
    end
  end

  // After reset, only accept an ss fall once ss has really been seen high,
  // so a select still held low through reset does not restart a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle   <= 2'd0;
      ss_armed <= 1'b0;
    end else begin
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && ss_sync) ss_armed <= 1'b1;
    end
  end

  // Edge classification on the synchronized pins.
  always_comb begin
    sclk_rise   = sclk_sync & ~sclk_prev;
    sclk_fall   = ~sclk_sync & sclk_prev;
    lead_edge   = clk_polarity ? sclk_fall : sclk_rise;
    trail_edge  = clk_polarity ? sclk_rise : sclk_fall;
    sample_edge = clk_phase ? trail_edge : lead_edge;
    shift_edge  = clk_phase ? lead_edge : trail_edge;
    ss_fall     = ss_prev & ~ss_sync & ss_armed;
    ss_rise     = ~ss_prev & ss_sync;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state: ss fall opens a transfer, ss rise closes it at any bit.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ss_fall) state_next = ACTIVE;
      ACTIVE:  if (ss_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: busy level and the strobes that steer the datapath.
  always_comb begin
    busy_int   = 1'b0;
    word_start = 1'b0;
    active_run = 1'b0;
    exit_word  = 1'b0;
    case (state)
      IDLE: word_start = ss_fall;
      ACTIVE: begin
        busy_int   = 1'b1;
        active_run = ~ss_rise;
        exit_word  = ss_rise;
      end
      default: ;
    endcase
  end

  // Word boundary and shift decisions for the current cycle.
  always_comb begin
    word_done = active_run & sample_edge & (bit_cnt == last_bit);
    load_next = active_run & (clk_phase ? word_done : (shift_edge & arm_pending));
    do_load   = word_start | load_next;
    do_shift  = active_run & shift_edge & ~skip_shift & ~load_next;
    tx_accept = bus.tx_valid & ~hold_full;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    rx_next = {mosi_sync, rx_shift[data_width-1:1]};
`else
    rx_next = {rx_shift[data_width-2:0], mosi_sync};
`endif
  end

  // Single-entry holding register; a load and a new accept may share a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      if (do_load) hold_full <= 1'b0;
      if (tx_accept) begin
        hold_full <= 1'b1;
        hold_data <= bus.tx_data;
      end
    end
  end

  // Transmit shift register: load at word start, shift on shift edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift      <= '0;
      skip_shift    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      tx_underrun_q <= do_load & ~hold_full;
      if (exit_word) begin
        tx_shift   <= '0;
        skip_shift <= 1'b0;
      end else if (do_load) begin
        tx_shift   <= hold_full ? hold_data : '0;
        skip_shift <= clk_phase;
      end else if (do_shift) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
        tx_shift <= tx_shift >> 1;
`else
        tx_shift <= tx_shift << 1;
`endif
      end else if (active_run & shift_edge & skip_shift) begin
        skip_shift <= 1'b0;
      end
    end
  end

  // Receive path: sample mosi, count bits, publish complete words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      bit_cnt     <= '0;
      arm_pending <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (exit_word || word_start) begin
        rx_shift    <= '0;
        bit_cnt     <= '0;
        arm_pending <= 1'b0;
      end else begin
        if (load_next) arm_pending <= 1'b0;
        if (active_run && sample_edge) begin
          rx_shift <= rx_next;
          if (bit_cnt == last_bit) begin
            rx_data_q   <= rx_next;
            rx_valid_q  <= 1'b1;
            bit_cnt     <= '0;
            arm_pending <= ~clk_phase;
          end else begin
            bit_cnt <= bit_cnt + cnt_w'(1);
          end
        end
      end
    end
  end

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign bus.miso = tx_shift[0];
`else
  assign bus.miso = tx_shift[data_width-1];
`endif
  assign bus.miso_oe     = ~ss_sync;
  assign bus.tx_ready    = ~hold_full;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.busy        = busy_int;

endmodule

// File: tb/tb_spi_slave_core.sv
// Testbench for spi_slave_core: one mode-0 and one mode-3 instance driven by
// a simple SPI master model, with an rx scoreboard and table-driven vectors.
module tb_spi_slave_core;

  localparam int DW = 16;
  localparam int H  = 8;

  typedef struct {
    int          sel;
    bit          has_tx;
    logic [15:0] tx;
    logic [15:0] mo;
    logic [15:0] exp_miso;
    int          exp_ur;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk_base = 1'b0;
  logic mosi_pin = 1'b0;
  logic ss0 = 1'b1;
  logic ss3 = 1'b1;
  logic [15:0] tx_data0 = '0;
  logic [15:0] tx_data3 = '0;
  logic tx_valid0 = 1'b0;
  logic tx_valid3 = 1'b0;

  int checks = 0;
  int errors = 0;
  int rxcnt[2];
  int urcnt[2];
  logic [15:0] rx_q0[$];
  logic [15:0] rx_q3[$];

  spi_slave_core_if #(.data_width(DW)) bus0 ();
  spi_slave_core_if #(.data_width(DW)) bus3 ();

  // Leading edge of both instances is a rise of sclk_base; mode 3 idles high.
  assign bus0.sclk     = sclk_base;
  assign bus3.sclk     = ~sclk_base;
  assign bus0.mosi     = mosi_pin;
  assign bus3.mosi     = mosi_pin;
  assign bus0.ss       = ss0;
  assign bus3.ss       = ss3;
  assign bus0.tx_data  = tx_data0;
  assign bus3.tx_data  = tx_data3;
  assign bus0.tx_valid = tx_valid0;
  assign bus3.tx_valid = tx_valid3;

  spi_slave_core #(.clk_polarity(1'b0), .clk_phase(1'b0), .data_width(DW)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  spi_slave_core #(.clk_polarity(1'b1), .clk_phase(1'b1), .data_width(DW)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Global time limit so the bench always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard: every rx_valid pops the word the master sent.
  always @(negedge clk) begin
    if (bus0.rx_valid) begin
      rxcnt[0]++;
      checkOutput("dut0 rx word expected", rx_q0.size() > 0, 1);
      if (rx_q0.size() > 0) checkOutput("dut0 rx_data", bus0.rx_data, rx_q0.pop_front());
    end
    if (bus3.rx_valid) begin
      rxcnt[1]++;
      checkOutput("dut3 rx word expected", rx_q3.size() > 0, 1);
      if (rx_q3.size() > 0) checkOutput("dut3 rx_data", bus3.rx_data, rx_q3.pop_front());
    end
    if (bus0.tx_underrun) urcnt[0]++;
    if (bus3.tx_underrun) urcnt[1]++;
  end

  function automatic logic get_miso(input int sel);
    return (sel == 0) ? bus0.miso : bus3.miso;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? bus0.busy : bus3.busy;
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus0.tx_ready : bus3.tx_ready;
  endfunction

  function automatic logic first_bit_of(input logic [15:0] w);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return w[0];
`else
    return w[15];
`endif
  endfunction

  task automatic set_ss(input int sel, input logic v);
    if (sel == 0) ss0 = v;
    else          ss3 = v;
  endtask

  task automatic push_tx(input int sel, input logic [15:0] w);
    int n;
    n = 0;
    while (!get_ready(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tx_ready before push", get_ready(sel), 1);
    if (sel == 0) begin
      tx_data0 = w;
      tx_valid0 = 1'b1;
    end else begin
      tx_data3 = w;
      tx_valid3 = 1'b1;
    end
    @(negedge clk);
    tx_valid0 = 1'b0;
    tx_valid3 = 1'b0;
  endtask

  // SPI master model: shifts nbits of one word; a full word is queued on the
  // scoreboard before the first bit goes out.
  task automatic xfer_word(input int sel, input int nbits, input logic [15:0] mo,
                           output logic [15:0] mi, output logic fb);
    int idx;
    mi = '0;
    fb = 1'b0;
    if (nbits == 16) begin
      if (sel == 0) rx_q0.push_back(mo);
      else          rx_q3.push_back(mo);
    end
    for (int i = 0; i < nbits; i++) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
      idx = i;
`else
      idx = 15 - i;
`endif
      if (sel == 0) begin
        mosi_pin = mo[idx];
        repeat (H) @(negedge clk);
        mi[idx] = get_miso(0);
        sclk_base = 1'b1;
        repeat (H) @(negedge clk);
        sclk_base = 1'b0;
      end else begin
        sclk_base = 1'b1;
        mosi_pin = mo[idx];
        repeat (H) @(negedge clk);
        mi[idx] = get_miso(1);
        sclk_base = 1'b0;
        repeat (H) @(negedge clk);
      end
      if (i == 0) fb = mi[idx];
    end
    if (sel == 0) repeat (H) @(negedge clk);
  endtask

  // One complete single-word transfer with a spare tx word for the next slot.
  task automatic applyStimulus(input vec_t v, input string tag);
    int rx0, ur0;
    logic [15:0] mi;
    logic fb;
    rx0 = rxcnt[v.sel];
    ur0 = urcnt[v.sel];
    if (v.has_tx) push_tx(v.sel, v.tx);
    set_ss(v.sel, 1'b0);
    repeat (H) @(negedge clk);
    checkOutput({tag, " busy during"}, get_busy(v.sel), 1);
    checkOutput({tag, " miso_oe during"}, (v.sel == 0) ? bus0.miso_oe : bus3.miso_oe, 1);
    push_tx(v.sel, 16'h5A5A);
    xfer_word(v.sel, 16, v.mo, mi, fb);
    set_ss(v.sel, 1'b1);
    repeat (H) @(negedge clk);
    checkOutput({tag, " miso word"}, mi, v.exp_miso);
    checkOutput({tag, " first bit"}, fb, first_bit_of(v.exp_miso));
    checkOutput({tag, " rx_valid count"}, rxcnt[v.sel] - rx0, 1);
    checkOutput({tag, " underrun count"}, urcnt[v.sel] - ur0, v.exp_ur);
    checkOutput({tag, " busy after"}, get_busy(v.sel), 0);
    checkOutput({tag, " tx_ready after"}, get_ready(v.sel), 1);
  endtask

  task automatic check_reset_values(input int sel, input string tag);
    if (sel == 0) begin
      checkOutput({tag, " miso"}, bus0.miso, 0);
      checkOutput({tag, " miso_oe"}, bus0.miso_oe, 0);
      checkOutput({tag, " tx_ready"}, bus0.tx_ready, 1);
      checkOutput({tag, " rx_data"}, bus0.rx_data, 0);
      checkOutput({tag, " rx_valid"}, bus0.rx_valid, 0);
      checkOutput({tag, " tx_underrun"}, bus0.tx_underrun, 0);
      checkOutput({tag, " busy"}, bus0.busy, 0);
    end else begin
      checkOutput({tag, " miso"}, bus3.miso, 0);
      checkOutput({tag, " miso_oe"}, bus3.miso_oe, 0);
      checkOutput({tag, " tx_ready"}, bus3.tx_ready, 1);
      checkOutput({tag, " rx_data"}, bus3.rx_data, 0);
      checkOutput({tag, " busy"}, bus3.busy, 0);
    end
  endtask

  // Main sequence.
  initial begin
    vec_t vecs[6];
    logic [15:0] mi;
    logic [15:0] mask;
    logic fb;
    int rx0, ur0;

    vecs[0] = '{0, 1'b1, 16'h3C3C, 16'hA5A5, 16'h3C3C, 0};
    vecs[1] = '{0, 1'b1, 16'h0001, 16'hFFFF, 16'h0001, 0};
    vecs[2] = '{1, 1'b1, 16'h8000, 16'h0001, 16'h8000, 0};
    vecs[3] = '{1, 1'b0, 16'h0000, 16'hBEEF, 16'h0000, 1};
    vecs[4] = '{0, 1'b0, 16'h0000, 16'h1248, 16'h0000, 1};
    vecs[5] = '{1, 1'b1, 16'h0001, 16'hA5A5, 16'h0001, 0};
    rxcnt[0] = 0; rxcnt[1] = 0;
    urcnt[0] = 0; urcnt[1] = 0;

    repeat (4) @(negedge clk);
    check_reset_values(0, "reset dut0");
    check_reset_values(1, "reset dut3");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Mode 3: two words back to back under one select.
    $display("[TB] mode 3 back-to-back words");
    rx0 = rxcnt[1];
    ur0 = urcnt[1];
    push_tx(1, 16'h1234);
    ss3 = 1'b0;
    repeat (H) @(negedge clk);
    push_tx(1, 16'hABCD);
    xfer_word(1, 16, 16'h0F0F, mi, fb);
    checkOutput("b2b word1 miso", mi, 16'h1234);
    push_tx(1, 16'h5555);
    xfer_word(1, 16, 16'hF0F0, mi, fb);
    checkOutput("b2b word2 miso", mi, 16'hABCD);
    ss3 = 1'b1;
    repeat (H) @(negedge clk);
    checkOutput("b2b rx_valid count", rxcnt[1] - rx0, 2);
    checkOutput("b2b underrun count", urcnt[1] - ur0, 0);
    checkOutput("b2b busy after", bus3.busy, 0);

    // Mode 0: select dropped after 7 bits.
    $display("[TB] abort after 7 bits");
    rx0 = rxcnt[0];
`ifdef SPI_SLAVE_LSB_FIRST_EN
    mask = 16'h007F;
`else
    mask = 16'hFE00;
`endif
    push_tx(0, 16'hC3C3);
    ss0 = 1'b0;
    repeat (H) @(negedge clk);
    xfer_word(0, 7, 16'hFFFF, mi, fb);
    ss0 = 1'b1;
    repeat (H) @(negedge clk);
    checkOutput("abort partial miso", mi & mask, 16'hC3C3 & mask);
    checkOutput("abort rx_valid count", rxcnt[0] - rx0, 0);
    checkOutput("abort busy after", bus0.busy, 0);
    checkOutput("abort miso cleared", bus0.miso, 0);
    applyStimulus('{0, 1'b1, 16'h9876, 16'h1357, 16'h9876, 0}, "post-abort");

    // Mode 0: reset asserted in the middle of a word.
    $display("[TB] reset mid-word");
    push_tx(0, 16'h1111);
    ss0 = 1'b0;
    repeat (H) @(negedge clk);
    xfer_word(0, 7, 16'h0F0F, mi, fb);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values(0, "mid reset dut0");
    ur0 = urcnt[0];
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("held ss no restart busy", bus0.busy, 0);
    checkOutput("held ss no restart underrun", urcnt[0] - ur0, 0);
    ss0 = 1'b1;
    repeat (H) @(negedge clk);
    applyStimulus('{0, 1'b1, 16'h4321, 16'hA5A5, 16'h4321, 0}, "post-reset");

    checkOutput("dut0 scoreboard drained", rx_q0.size(), 0);
    checkOutput("dut3 scoreboard drained", rx_q3.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
